// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC/MDIO in clk_125, decodes read/write
// frames and serves a 32x16 register file with constant ID and status registers.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter logic [15:0] PHY_ID1     = 16'h0141,
    parameter logic [15:0] PHY_ID2     = 16'h0CC2,
    parameter logic [15:0] STATUS_BASE = 16'h7949,
    parameter int          PREAMBLE    = 32
) (
    input  logic        clk_125,
    input  logic        global_reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);
    localparam int            PW      = $clog2(PREAMBLE + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE);

    typedef enum logic [3:0] {
        S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_WR_TA, S_WR_DATA, S_RD_TA, S_RD_DATA
    } state_t;

    state_t        state, state_n;
    logic [1:0]    mdc_s, mdio_s;
    logic          mdc_q, rise, fall, bit_in;
    logic [PW-1:0] pre_cnt, pre_cnt_n;
    logic [4:0]    bit_cnt, bit_cnt_n, phyad, phyad_n, regad, regad_n, rd_addr, wr_addr_n;
    logic [15:0]   sr, sr_n, rd_data, rd_data_n, rd_mux, wr_data_n;
    logic          is_read, is_read_n, match, match_n;
    logic          mdio_out_n, mdio_oen_n, wr_stb_n, frame_err_n, reg_we, soft_rst;
    logic [15:0]   regs [32];

    always_ff @(posedge clk_125 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            mdc_s  <= 2'b11;
            mdc_q  <= 1'b1;
            mdio_s <= 2'b11;
        end else begin
            mdc_s  <= {mdc_s[0], mdc};
            mdc_q  <= mdc_s[1];
            mdio_s <= {mdio_s[0], mdio_in};
        end
    end

    assign rise    = mdc_s[1] & ~mdc_q;
    assign fall    = ~mdc_s[1] & mdc_q;
    assign bit_in  = mdio_s[1];
    // full register address as it stands on the REGAD LSB sample
    assign rd_addr = {regad[3:0], bit_in};

    always_comb begin
        rd_mux = regs[rd_addr];
        case (rd_addr)
            5'd1: begin
                rd_mux    = STATUS_BASE;
                rd_mux[2] = link_up;
            end
            5'd2:    rd_mux = PHY_ID1;
            5'd3:    rd_mux = PHY_ID2;
            default: ;
        endcase
    end

    always_comb begin
        state_n     = state;
        pre_cnt_n   = pre_cnt;
        bit_cnt_n   = bit_cnt;
        phyad_n     = phyad;
        regad_n     = regad;
        sr_n        = sr;
        rd_data_n   = rd_data;
        is_read_n   = is_read;
        match_n     = match;
        mdio_out_n  = mdio_out;
        mdio_oen_n  = mdio_oen;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        wr_stb_n    = 1'b0;
        frame_err_n = 1'b0;
        reg_we      = 1'b0;
        soft_rst    = 1'b0;
        case (state)
            S_IDLE: if (rise) begin
                if (bit_in) begin
                    if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + 1'b1;
                end else if (pre_cnt == PRE_MAX) begin
                    state_n = S_ST2;
                end else begin
                    pre_cnt_n = '0;
                end
            end
            S_ST2: if (rise) begin
                bit_cnt_n = '0;
                if (bit_in) begin
                    state_n = S_OP;
                end else begin
                    frame_err_n = 1'b1;
                    state_n     = S_IDLE;
                    pre_cnt_n   = '0;
                end
            end
            S_OP: if (rise) begin
                sr_n      = {sr[14:0], bit_in};
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 5'd1) begin
                    bit_cnt_n = '0;
                    case ({sr[0], bit_in})
                        2'b10: begin is_read_n = 1'b1; state_n = S_PHYAD; end
                        2'b01: begin is_read_n = 1'b0; state_n = S_PHYAD; end
                        default: begin
                            frame_err_n = 1'b1;
                            state_n     = S_IDLE;
                            pre_cnt_n   = '0;
                        end
                    endcase
                end
            end
            S_PHYAD: if (rise) begin
                phyad_n   = {phyad[3:0], bit_in};
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 5'd4) begin
                    bit_cnt_n = '0;
                    state_n   = S_REGAD;
                end
            end
            S_REGAD: if (rise) begin
                regad_n   = rd_addr;
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 5'd4) begin
                    bit_cnt_n = '0;
                    match_n   = (phyad == PHY_ADDR);
                    rd_data_n = rd_mux;
                    state_n   = is_read ? S_RD_TA : S_WR_TA;
                end
            end
            S_WR_TA: if (rise) begin
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 5'd1) begin
                    bit_cnt_n = '0;
                    if (bit_in) begin
                        frame_err_n = 1'b1;
                        state_n     = S_IDLE;
                        pre_cnt_n   = '0;
                    end else begin
                        state_n = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: if (rise) begin
                sr_n      = {sr[14:0], bit_in};
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 5'd15) begin
                    if (match) begin
                        wr_stb_n  = 1'b1;
                        wr_addr_n = regad;
                        wr_data_n = sr_n;
                        soft_rst  = (regad == 5'd0) && sr_n[15];
                        reg_we    = !(regad inside {5'd1, 5'd2, 5'd3});
                    end
                    state_n   = S_IDLE;
                    pre_cnt_n = '0;
                end
            end
            // read turnaround: first fall stays released, second drives the 0
            S_RD_TA: if (fall) begin
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 5'd1) begin
                    bit_cnt_n = '0;
                    state_n   = S_RD_DATA;
                    if (match) begin
                        mdio_oen_n = 1'b0;
                        mdio_out_n = 1'b0;
                    end
                end
            end
            S_RD_DATA: if (fall) begin
                if (bit_cnt == 5'd16) begin
                    mdio_oen_n = 1'b1;
                    mdio_out_n = 1'b1;
                    state_n    = S_IDLE;
                    pre_cnt_n  = '0;
                end else begin
                    if (match) mdio_out_n = rd_data[15];
                    rd_data_n = {rd_data[14:0], 1'b0};
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = S_IDLE;
                pre_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_125 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state     <= S_IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            phyad     <= '0;
            regad     <= '0;
            sr        <= '0;
            rd_data   <= '0;
            is_read   <= 1'b0;
            match     <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_oen  <= 1'b1;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            pre_cnt   <= pre_cnt_n;
            bit_cnt   <= bit_cnt_n;
            phyad     <= phyad_n;
            regad     <= regad_n;
            sr        <= sr_n;
            rd_data   <= rd_data_n;
            is_read   <= is_read_n;
            match     <= match_n;
            mdio_out  <= mdio_out_n;
            mdio_oen  <= mdio_oen_n;
            wr_stb    <= wr_stb_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            frame_err <= frame_err_n;
        end
    end

    // regs 1..3 are never written; reg 0 bit 15 is self-clearing soft reset
    always_ff @(posedge clk_125 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (soft_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[regad] <= (regad == 5'd0) ? {1'b0, sr_n[14:0]} : sr_n;
        end
    end
endmodule
